// File: rtl/counter_cmd_sched_pkg.sv
// counter_cmd_sched_pkg
// Shared definitions for the counter command scheduler:
//   - op encoding constants (OP_INC, OP_DEC, OP_LOAD, OP_CLR)
//   - FSM state enum (ST_IDLE, ST_EXEC)
//   - next_count(): next counter value for a given op, count and load data
// Configuration macro: COUNTER_CMD_SCHED_WRAP_EN
//   defined   -> inc/dec wrap modulo 2^width
//   undefined -> inc/dec saturate at all-ones / zero
package counter_cmd_sched_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } state_e;

  // Works on a 32-bit container so one function serves any counter width
  // up to 32; the caller truncates the result back to its own width.
  function automatic logic [31:0] next_count(input logic [1:0]  op,
                                             input logic [31:0] cnt,
                                             input logic [31:0] data,
                                             input int          width);
    logic [31:0] maxv;
    maxv = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    next_count = cnt;
    case (op)
      OP_INC: begin
`ifdef COUNTER_CMD_SCHED_WRAP_EN
        next_count = (cnt + 32'd1) & maxv;
`else
        if (cnt != maxv) next_count = cnt + 32'd1;
`endif
      end
      OP_DEC: begin
`ifdef COUNTER_CMD_SCHED_WRAP_EN
        next_count = (cnt - 32'd1) & maxv;
`else
        if (cnt != 32'd0) next_count = cnt - 32'd1;
`endif
      end
      OP_LOAD: next_count = data & maxv;
      default: next_count = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/counter_cmd_sched_rr_arbiter.sv
// rr_arbiter
// Combinational N-way round-robin pick: the first valid requester at or
// after the pointer, searching upward and wrapping.
// Ports:
//   valid_i  N   request vector
//   ptr_i    IW  search start index
//   grant_o  N   one-hot grant (all zero when nothing is valid)
//   idx_o    IW  index of the granted requester
//   any_o    1   at least one requester is valid
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/counter_cmd_sched.sv
// counter_cmd_sched
// Shares one up/down/load counter between N_REQ requesters and an internal
// autocount tick. Round-robin arbitration, one command per two clocks
// (IDLE captures, EXEC applies), terminal-count event pulses.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req_valid[N_REQ]      per-requester command valid (held until ready)
//   req_op[2*N_REQ]       per-requester op, slice i = bits 2i+1:2i
//   req_data[WIDTH*N_REQ] per-requester load value
//   req_ready[N_REQ]      one-hot completion pulse, high during EXEC
//   auto_en               enables autocount ticks
//   count[WIDTH]          counter value
//   evt_zero, evt_max     one-cycle pulses on transition to 0 / all-ones
//   tick_overrun          sticky: a tick expired while one was pending
//   busy                  high in EXEC
// Configuration macro: COUNTER_CMD_SCHED_WRAP_EN (wrap instead of saturate).
// WIDTH must not exceed 32.
module counter_cmd_sched
  import counter_cmd_sched_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter int          WIDTH    = 8,
  parameter logic [23:0] DIV_INIT = 24'h100000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   auto_en,
  output logic [WIDTH-1:0]       count,
  output logic                   evt_zero,
  output logic                   evt_max,
  output logic                   tick_overrun,
  output logic                   busy
);

  localparam int PW = $clog2(N_REQ);

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     winner_q;
  logic              isTick_q;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  count_q;
  logic [N_REQ-1:0]  ready_q;
  logic              evtZero_q;
  logic              evtMax_q;
  logic              busy_q;
  logic [23:0]       div_q;
  logic              tickPend_q;
  logic              overrun_q;

  logic [N_REQ-1:0]  grant;
  logic [PW-1:0]     grantIdx;
  logic              anyValid;
  logic [1:0]        selOp;
  logic [WIDTH-1:0]  selData;
  logic [WIDTH-1:0]  count_d;
  logic              divExpire;
  logic              consumeTick;

  rr_arbiter #(.N(N_REQ), .IW(PW)) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grantIdx),
    .any_o   (anyValid)
  );

  // Route the winner's op/data slice to the capture registers.
  always_comb begin
    selOp   = OP_INC;
    selData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantIdx == PW'(i)) begin
        selOp   = req_op[2*i +: 2];
        selData = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  assign count_d     = WIDTH'(next_count(op_q, 32'(count_q), 32'(data_q), WIDTH));
  assign divExpire   = (div_q == '0);
  // A pending tick is only taken in IDLE when no requester is asking.
  assign consumeTick = (state_q == ST_IDLE) && !anyValid && tickPend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      winner_q   <= '0;
      isTick_q   <= 1'b0;
      op_q       <= OP_INC;
      data_q     <= '0;
      count_q    <= '0;
      ready_q    <= '0;
      evtZero_q  <= 1'b0;
      evtMax_q   <= 1'b0;
      busy_q     <= 1'b0;
      div_q      <= DIV_INIT;
      tickPend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (divExpire) div_q <= DIV_INIT;
      else           div_q <= div_q - 24'd1;

      // An expiry in the same cycle a tick is consumed just re-arms the
      // pending flag; only an expiry on top of an unconsumed tick overruns.
      if (divExpire && auto_en) begin
        tickPend_q <= 1'b1;
        if (tickPend_q && !consumeTick) overrun_q <= 1'b1;
      end else if (consumeTick) begin
        tickPend_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          evtZero_q <= 1'b0;
          evtMax_q  <= 1'b0;
          ready_q   <= '0;
          if (anyValid) begin
            ready_q  <= grant;
            winner_q <= grantIdx;
            op_q     <= selOp;
            data_q   <= selData;
            isTick_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_EXEC;
          end else if (tickPend_q) begin
            op_q     <= OP_INC;
            isTick_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          count_q   <= count_d;
          evtZero_q <= (count_d == '0) && (count_q != '0);
          evtMax_q  <= (&count_d) && !(&count_q);
          ready_q   <= '0;
          busy_q    <= 1'b0;
          if (!isTick_q)
            ptr_q <= (winner_q == PW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
          if (op_q == OP_CLR) overrun_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign count        = count_q;
  assign evt_zero     = evtZero_q;
  assign evt_max      = evtMax_q;
  assign tick_overrun = overrun_q;
  assign busy         = busy_q;

endmodule
